// File: rtl/aer_spike_sequencer_if.sv
// Bus bundle between the spike sequencer, the bitmap memory and the core's AER input.
//   MEM_EN     : read strobe (sequencer -> memory)
//   MEM_ADDR   : byte address (sequencer -> memory)
//   MEM_RDATA  : read data, valid the cycle after MEM_EN (memory -> sequencer)
//   AERIN_ADDR : event address (sequencer -> core)
//   AERIN_REQ  : 4-phase request (sequencer -> core)
//   AERIN_ACK  : 4-phase acknowledge (core -> sequencer)
interface aer_spike_sequencer_if #(
    parameter int unsigned MEM_AW = 20
);
    logic              MEM_EN;
    logic [MEM_AW-1:0] MEM_ADDR;
    logic [7:0]        MEM_RDATA;
    logic [11:0]       AERIN_ADDR;
    logic              AERIN_REQ;
    logic              AERIN_ACK;

    modport master (
        output MEM_EN,
        output MEM_ADDR,
        input  MEM_RDATA,
        output AERIN_ADDR,
        output AERIN_REQ,
        input  AERIN_ACK
    );

    modport slave (
        input  MEM_EN,
        input  MEM_ADDR,
        output MEM_RDATA,
        input  AERIN_ADDR,
        input  AERIN_REQ,
        output AERIN_ACK
    );
endinterface

// File: rtl/aer_spike_sequencer.sv
// Streams pre-encoded spike bitmaps (sample x step x pixel, 1 bit/pixel, MSB = lowest pixel)
// from a byte-wide sync-read memory into the core's AER input with a 4-phase handshake.
// Each time step is closed by a marker event at TICK_ADDR; after each sample the block waits
// for PROCESS_DONE and advances the IS_POS / IS_TRAIN mode lines.
// Ports:
//   CLK, RST_N        : clock, asynchronous active-low reset
//   START             : 1-cycle start pulse, ignored while BUSY
//   NUM_SAMPLES       : samples to run (latched at START)
//   TRAIN_SAMPLES     : leading samples run in train mode (latched at START)
//   TRAIN_EN, POS_INIT: global train enable, IS_POS for sample 0 (latched at START)
//   PROCESS_DONE      : core end-of-sample pulse, only honoured while waiting for it
//   IS_POS, IS_TRAIN  : mode lines to the core
//   SAMPLE_IDX        : current sample index
//   BUSY, DONE        : run in progress, 1-cycle completion pulse
//   aer_bus           : memory read port and AER output (master side)
module aer_spike_sequencer #(
    parameter int unsigned N_PIX     = 784,
    parameter int unsigned T_STEPS   = 8,
    parameter int unsigned MEM_AW    = 20,
    parameter logic [11:0] TICK_ADDR = 12'h4FF
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         START,
    input  logic [15:0]                  NUM_SAMPLES,
    input  logic [15:0]                  TRAIN_SAMPLES,
    input  logic                         TRAIN_EN,
    input  logic                         POS_INIT,
    input  logic                         PROCESS_DONE,
    output logic                         IS_POS,
    output logic                         IS_TRAIN,
    output logic [15:0]                  SAMPLE_IDX,
    output logic                         BUSY,
    output logic                         DONE,
    aer_spike_sequencer_if.master        aer_bus
);

    localparam int unsigned BytesPerStep = N_PIX / 8;
    localparam int unsigned ByteW = (BytesPerStep > 1) ? $clog2(BytesPerStep) : 1;
    localparam int unsigned StepW = (T_STEPS > 1) ? $clog2(T_STEPS) : 1;
    localparam logic [ByteW-1:0] LastByte = ByteW'(BytesPerStep - 1);
    localparam logic [StepW-1:0] LastStep = StepW'(T_STEPS - 1);

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StLoad,
        StScan,
        StSetup,
        StReqHi,
        StReqLo,
        StWaitDone,
        StFin
    } state_e;

    state_e            state_q, state_d;
    logic [MEM_AW-1:0] ptr_q, ptr_d;
    logic [ByteW-1:0]  byte_q, byte_d;
    logic [StepW-1:0]  step_q, step_d;
    logic [3:0]        bit_q, bit_d;      // 0..7 = next bit to examine, 8 = byte exhausted
    logic [7:0]        shift_q, shift_d;
    logic              marker_q, marker_d;
    logic [11:0]       addr_q, addr_d;
    logic              req_q, req_d;
    logic [15:0]       num_q, num_d;
    logic [15:0]       train_num_q, train_num_d;
    logic              train_en_q, train_en_d;
    logic              is_pos_q, is_pos_d;
    logic              is_train_q, is_train_d;
    logic [15:0]       idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [ByteW+2:0]  pix_idx;
    logic [15:0]       idx_inc;
    logic              eob;

    assign pix_idx = {byte_q, bit_q[2:0]};
    assign idx_inc = idx_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        byte_d      = byte_q;
        step_d      = step_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        marker_d    = marker_q;
        addr_d      = addr_q;
        req_d       = req_q;
        num_d       = num_q;
        train_num_d = train_num_q;
        train_en_d  = train_en_q;
        is_pos_d    = is_pos_q;
        is_train_d  = is_train_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        eob         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (START) begin
                    num_d       = NUM_SAMPLES;
                    train_num_d = TRAIN_SAMPLES;
                    train_en_d  = TRAIN_EN;
                    idx_d       = 16'd0;
                    is_pos_d    = POS_INIT;
                    is_train_d  = TRAIN_EN & (TRAIN_SAMPLES != 16'd0);
                    ptr_d       = '0;
                    byte_d      = '0;
                    step_d      = '0;
                    bit_d       = 4'd0;
                    busy_d      = 1'b1;
                    state_d     = (NUM_SAMPLES == 16'd0) ? StFin : StFetch;
                end
            end
            StFetch: state_d = StLoad;
            StLoad: begin
                shift_d = aer_bus.MEM_RDATA;
                bit_d   = 4'd0;
                if (aer_bus.MEM_RDATA == 8'd0) begin
                    eob = 1'b1;
                end else begin
                    state_d = StScan;
                end
            end
            StScan: begin
                if (bit_q[3]) begin
                    // Last bit was set: its event has completed, close out the byte.
                    eob = 1'b1;
                end else begin
                    shift_d = {shift_q[6:0], 1'b0};
                    bit_d   = bit_q + 4'd1;
                    if (shift_q[7]) begin
                        addr_d   = {2'b00, 10'(pix_idx)};
                        marker_d = 1'b0;
                        state_d  = StSetup;
                    end else if (bit_q[2:0] == 3'd7) begin
                        eob = 1'b1;
                    end
                end
            end
            StSetup: begin
                if (!aer_bus.AERIN_ACK) begin
                    req_d   = 1'b1;
                    state_d = StReqHi;
                end
            end
            StReqHi: begin
                if (aer_bus.AERIN_ACK) begin
                    req_d   = 1'b0;
                    state_d = StReqLo;
                end
            end
            StReqLo: begin
                if (!aer_bus.AERIN_ACK) begin
                    if (!marker_q) begin
                        state_d = StScan;
                    end else if (step_q != LastStep) begin
                        step_d  = step_q + 1'b1;
                        byte_d  = '0;
                        state_d = StFetch;
                    end else begin
                        step_d  = '0;
                        byte_d  = '0;
                        state_d = StWaitDone;
                    end
                end
            end
            StWaitDone: begin
                if (PROCESS_DONE) begin
                    is_pos_d   = ~is_pos_q;
                    idx_d      = idx_inc;
                    is_train_d = train_en_q & (idx_inc < train_num_q);
                    state_d    = (idx_inc == num_q) ? StFin : StFetch;
                end
            end
            StFin: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // End of byte: advance the running pointer; after the last byte of a step, emit a marker.
        if (eob) begin
            ptr_d = ptr_q + 1'b1;
            if (byte_q != LastByte) begin
                byte_d  = byte_q + 1'b1;
                state_d = StFetch;
            end else begin
                addr_d   = TICK_ADDR;
                marker_d = 1'b1;
                state_d  = StSetup;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            byte_q      <= '0;
            step_q      <= '0;
            bit_q       <= 4'd0;
            shift_q     <= 8'd0;
            marker_q    <= 1'b0;
            addr_q      <= 12'd0;
            req_q       <= 1'b0;
            num_q       <= 16'd0;
            train_num_q <= 16'd0;
            train_en_q  <= 1'b0;
            is_pos_q    <= 1'b0;
            is_train_q  <= 1'b0;
            idx_q       <= 16'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            byte_q      <= byte_d;
            step_q      <= step_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            marker_q    <= marker_d;
            addr_q      <= addr_d;
            req_q       <= req_d;
            num_q       <= num_d;
            train_num_q <= train_num_d;
            train_en_q  <= train_en_d;
            is_pos_q    <= is_pos_d;
            is_train_q  <= is_train_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign aer_bus.MEM_EN     = (state_q == StFetch);
    assign aer_bus.MEM_ADDR   = ptr_q;
    assign aer_bus.AERIN_ADDR = addr_q;
    assign aer_bus.AERIN_REQ  = req_q;

    assign IS_POS     = is_pos_q;
    assign IS_TRAIN   = is_train_q;
    assign SAMPLE_IDX = idx_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;

endmodule

// File: tb/tb_aer_spike_sequencer.sv
// Directed bench for aer_spike_sequencer: memory model, 4-phase ACK responder with
// programmable delays, event monitor, and a linear sequence of directed checks.
module tb_aer_spike_sequencer;

    localparam int unsigned MemAw = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_samples = 16'd0;
    logic [15:0] train_samples = 16'd0;
    logic        train_en = 1'b0;
    logic        pos_init = 1'b0;
    logic        process_done = 1'b0;
    logic        is_pos, is_train, busy, done;
    logic [15:0] sample_idx;

    aer_spike_sequencer_if #(.MEM_AW(MemAw)) aer_bus ();

    aer_spike_sequencer #(
        .N_PIX    (784),
        .T_STEPS  (8),
        .MEM_AW   (MemAw),
        .TICK_ADDR(12'h4FF)
    ) dut (
        .CLK          (clk),
        .RST_N        (rst_n),
        .START        (start),
        .NUM_SAMPLES  (num_samples),
        .TRAIN_SAMPLES(train_samples),
        .TRAIN_EN     (train_en),
        .POS_INIT     (pos_init),
        .PROCESS_DONE (process_done),
        .IS_POS       (is_pos),
        .IS_TRAIN     (is_train),
        .SAMPLE_IDX   (sample_idx),
        .BUSY         (busy),
        .DONE         (done),
        .aer_bus      (aer_bus)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  mem [0:4095];
    int          rd_cnt [0:4095];
    int          rd_total, rd_oob;
    logic [11:0] first_rd;
    bit          rd_pend;
    logic [11:0] rd_addr;

    int          ack_hi_dly = 2;
    int          ack_lo_dly = 2;
    int          ack_cnt;
    bit          req_prev, in_hs, ack_seen;
    logic [11:0] cur_addr;
    int          ev_cnt, mk_cnt, stab_viol, early_req, drop_viol, min_hi, hi_len, done_cnt;
    logic [11:0] ev_log [$];

    // Sync-read memory: data appears only in the cycle after MEM_EN, junk otherwise.
    initial begin
        aer_bus.MEM_RDATA = 8'hA5;
        rd_pend = 1'b0;
        forever begin
            @(negedge clk);
            aer_bus.MEM_RDATA = rd_pend ? mem[rd_addr] : 8'hA5;
            rd_pend = 1'b0;
            if (aer_bus.MEM_EN) begin
                if (aer_bus.MEM_ADDR >= 20'd4096) begin
                    rd_oob++;
                end else begin
                    rd_addr = aer_bus.MEM_ADDR[11:0];
                    rd_pend = 1'b1;
                    rd_cnt[rd_addr]++;
                    if (rd_total == 0) first_rd = rd_addr;
                end
                rd_total++;
            end
        end
    end

    // Event monitor followed by the ACK responder (same process, so no ordering race).
    initial begin
        aer_bus.AERIN_ACK = 1'b0;
        ack_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                aer_bus.AERIN_ACK = 1'b0;
                ack_cnt = 0;
                req_prev = 1'b0;
                in_hs = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (aer_bus.AERIN_REQ && !req_prev) begin
                    ev_log.push_back(aer_bus.AERIN_ADDR);
                    ev_cnt++;
                    if (aer_bus.AERIN_ADDR == 12'h4FF) mk_cnt++;
                    if (aer_bus.AERIN_ACK) early_req++;
                    cur_addr = aer_bus.AERIN_ADDR;
                    in_hs = 1'b1;
                    ack_seen = 1'b0;
                    hi_len = 0;
                end
                if (in_hs && aer_bus.AERIN_ADDR != cur_addr) stab_viol++;
                if (in_hs && aer_bus.AERIN_ACK) ack_seen = 1'b1;
                if (aer_bus.AERIN_REQ) hi_len++;
                if (!aer_bus.AERIN_REQ && req_prev) begin
                    if (!ack_seen) drop_viol++;
                    if (hi_len < min_hi) min_hi = hi_len;
                end
                if (!aer_bus.AERIN_REQ && !aer_bus.AERIN_ACK) in_hs = 1'b0;
                req_prev = aer_bus.AERIN_REQ;

                if (aer_bus.AERIN_REQ && !aer_bus.AERIN_ACK) begin
                    ack_cnt++;
                    if (ack_cnt >= ack_hi_dly) begin
                        aer_bus.AERIN_ACK = 1'b1;
                        ack_cnt = 0;
                    end
                end else if (!aer_bus.AERIN_REQ && aer_bus.AERIN_ACK) begin
                    ack_cnt++;
                    if (ack_cnt >= ack_lo_dly) begin
                        aer_bus.AERIN_ACK = 1'b0;
                        ack_cnt = 0;
                    end
                end else begin
                    ack_cnt = 0;
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        ev_log.delete();
        ev_cnt = 0; mk_cnt = 0; stab_viol = 0; early_req = 0; drop_viol = 0;
        min_hi = 1000000; done_cnt = 0; rd_total = 0; rd_oob = 0; first_rd = 12'hFFF;
        for (int i = 0; i < 4096; i++) rd_cnt[i] = 0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_markers(input int target, input string tag);
        int k = 0;
        while (mk_cnt < target && k < 40000) begin
            step(1);
            k++;
        end
        check(tag, 32'(mk_cnt >= target), 32'd1);
    endtask

    task automatic finish_sample(input string tag);
        int k = 0;
        while ((aer_bus.AERIN_REQ || aer_bus.AERIN_ACK) && k < 2000) begin
            step(1);
            k++;
        end
        check(tag, 32'(k < 2000), 32'd1);
        step(3);
        process_done = 1'b1;
        step(1);
        process_done = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < 100) begin
            step(1);
            k++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    logic [11:0] exp_t3 [10];
    int          bad;

    initial begin
        exp_t3 = '{12'h000, 12'h4FF, 12'h4FF, 12'h4FF, 12'h4FF, 12'h4FF, 12'h4FF, 12'h4FF,
                   12'h30F, 12'h4FF};
        clear_mem();
        clear_stats();

        // Reset state
        step(3);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_req", aer_bus.AERIN_REQ, 1'b0);
        check("rst_mem_en", aer_bus.MEM_EN, 1'b0);
        check("rst_is_pos", is_pos, 1'b0);
        check("rst_is_train", is_train, 1'b0);
        check("rst_idx", sample_idx, 16'd0);
        check("rst_aer_addr", aer_bus.AERIN_ADDR, 12'd0);
        check("rst_mem_addr", aer_bus.MEM_ADDR, 20'd0);
        rst_n = 1'b1;
        step(2);

        // T2: one all-zero sample, ACK after 2 cycles -> 8 markers only
        ack_hi_dly = 2; ack_lo_dly = 2;
        num_samples = 16'd1; pos_init = 1'b0; train_en = 1'b0; train_samples = 16'd0;
        clear_stats();
        pulse_start();
        check("t2_busy", busy, 1'b1);
        wait_markers(8, "t2_markers_seen");
        finish_sample("t2_hs_idle");
        wait_done("t2_done_seen");
        step(3);
        check("t2_ev_cnt", ev_cnt, 32'd8);
        check("t2_mk_cnt", mk_cnt, 32'd8);
        check("t2_done_cnt", done_cnt, 32'd1);
        check("t2_idx", sample_idx, 16'd1);
        check("t2_busy_end", busy, 1'b0);
        check("t2_is_pos", is_pos, 1'b1);
        check("t2_rd_total", rd_total, 32'd784);

        // T3: pixel 0 at t=0, pixel 783 at t=7
        clear_mem();
        mem[0] = 8'h80;
        mem[783] = 8'h01;
        clear_stats();
        pulse_start();
        wait_markers(8, "t3_markers_seen");
        finish_sample("t3_hs_idle");
        wait_done("t3_done_seen");
        check("t3_ev_cnt", ev_cnt, 32'd10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t3_ev%0d", i), (i < ev_log.size()) ? ev_log[i] : 12'hDEA,
                  exp_t3[i]);
        end
        bad = 0;
        for (int i = 0; i < 784; i++) if (rd_cnt[i] != 1) bad++;
        check("t3_rd_once", bad, 32'd0);
        check("t3_rd_total", rd_total, 32'd784);
        check("t3_rd_oob", rd_oob, 32'd0);

        // T4: slow ACK (25 high / 25 low), pixels 40 and 42 at t=0
        clear_mem();
        mem[5] = 8'hA0;
        ack_hi_dly = 25; ack_lo_dly = 25;
        clear_stats();
        pulse_start();
        wait_markers(8, "t4_markers_seen");
        finish_sample("t4_hs_idle");
        wait_done("t4_done_seen");
        check("t4_ev_cnt", ev_cnt, 32'd10);
        check("t4_ev0", (ev_log.size() > 0) ? ev_log[0] : 12'hDEA, 12'h028);
        check("t4_ev1", (ev_log.size() > 1) ? ev_log[1] : 12'hDEA, 12'h02A);
        check("t4_addr_stable", stab_viol, 32'd0);
        check("t4_no_early_req", early_req, 32'd0);
        check("t4_req_held", drop_viol, 32'd0);
        check("t4_min_hi", 32'(min_hi >= 25), 32'd1);

        // T5: 3 samples, mode-line sequencing, spurious PROCESS_DONE, START while busy
        clear_mem();
        ack_hi_dly = 1; ack_lo_dly = 1;
        num_samples = 16'd3; pos_init = 1'b1; train_en = 1'b1; train_samples = 16'd2;
        clear_stats();
        pulse_start();
        check("t5_s0_pos", is_pos, 1'b1);
        check("t5_s0_train", is_train, 1'b1);
        check("t5_s0_idx", sample_idx, 16'd0);
        wait_markers(1, "t5_first_marker");
        process_done = 1'b1;
        step(1);
        process_done = 1'b0;
        step(2);
        check("t5_spur_idx", sample_idx, 16'd0);
        check("t5_spur_pos", is_pos, 1'b1);
        num_samples = 16'd0;
        pulse_start();
        step(2);
        check("t5_restart_busy", busy, 1'b1);
        check("t5_restart_done", done_cnt, 32'd0);
        wait_markers(8, "t5_s0_markers");
        finish_sample("t5_s0_hs");
        check("t5_s1_pos", is_pos, 1'b0);
        check("t5_s1_train", is_train, 1'b1);
        check("t5_s1_idx", sample_idx, 16'd1);
        wait_markers(16, "t5_s1_markers");
        finish_sample("t5_s1_hs");
        check("t5_s2_pos", is_pos, 1'b1);
        check("t5_s2_train", is_train, 1'b0);
        check("t5_s2_idx", sample_idx, 16'd2);
        wait_markers(24, "t5_s2_markers");
        finish_sample("t5_s2_hs");
        wait_done("t5_done_seen");
        step(2);
        check("t5_end_idx", sample_idx, 16'd3);
        check("t5_end_pos", is_pos, 1'b0);
        check("t5_ev_cnt", ev_cnt, 32'd24);
        check("t5_done_cnt", done_cnt, 32'd1);
        check("t5_rd_total", rd_total, 32'd2352);

        // T6: async reset while REQ is high, then a clean restart
        clear_mem();
        mem[0] = 8'hFF;
        ack_hi_dly = 25; ack_lo_dly = 25;
        num_samples = 16'd1; pos_init = 1'b0; train_en = 1'b0; train_samples = 16'd0;
        clear_stats();
        pulse_start();
        begin
            int k = 0;
            while (!aer_bus.AERIN_REQ && k < 2000) begin
                step(1);
                k++;
            end
        end
        check("t6_req_seen", aer_bus.AERIN_REQ, 1'b1);
        step(5);
        #1 rst_n = 1'b0;
        #1;
        check("t6_req_async", aer_bus.AERIN_REQ, 1'b0);
        check("t6_busy_async", busy, 1'b0);
        check("t6_idx_async", sample_idx, 16'd0);
        ack_hi_dly = 1; ack_lo_dly = 1;
        step(3);
        rst_n = 1'b1;
        clear_stats();
        step(10);
        check("t6_no_resume_rd", rd_total, 32'd0);
        check("t6_no_resume_ev", ev_cnt, 32'd0);
        pulse_start();
        wait_markers(8, "t6_markers_seen");
        check("t6_first_rd", first_rd, 12'd0);
        check("t6_idx_run", sample_idx, 16'd0);
        check("t6_ev_cnt", ev_cnt, 32'd16);
        check("t6_ev0", (ev_log.size() > 0) ? ev_log[0] : 12'hDEA, 12'h000);
        check("t6_ev7", (ev_log.size() > 7) ? ev_log[7] : 12'hDEA, 12'h007);
        finish_sample("t6_hs_idle");
        wait_done("t6_done_seen");
        check("t6_idx_end", sample_idx, 16'd1);

        // T7: NUM_SAMPLES = 0 -> DONE two cycles after START, no traffic
        num_samples = 16'd0;
        clear_stats();
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("t7_done_c1", done, 1'b0);
        check("t7_busy_c1", busy, 1'b1);
        step(1);
        check("t7_done_c2", done, 1'b1);
        check("t7_busy_c2", busy, 1'b0);
        step(1);
        check("t7_done_c3", done, 1'b0);
        step(5);
        check("t7_no_rd", rd_total, 32'd0);
        check("t7_no_req", ev_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/aer_spike_sequencer.md
Name: aer_spike_sequencer

Overview:
On-chip replacement for the bench-side spike driver. Streams pre-encoded spike bitmaps (samples × time steps × pixels, 1 bit/pixel, MSB-first bytes) from a byte-wide sync-read memory into the core's AER input port using a 4-phase handshake. After each pixel time step it inserts a time-step marker event. After each sample it waits for PROCESS_DONE and sequences the IS_POS / IS_TRAIN mode lines.

Parameters:
N_PIX, 784, pixels per time step; must be a multiple of 8.
T_STEPS, 8, time steps per sample.
MEM_AW, 20, memory byte-address width.
TICK_ADDR, 12'h4FF, AER address of the time-step marker ({1'b0,1'b1,10'h0FF}).

Ports:
CLK  in  1  clock
RST_N  in  1  reset, asynchronous, active-low
START  in  1  1-cycle pulse; ignored while BUSY
NUM_SAMPLES  in  16  samples to run, sampled at START
TRAIN_SAMPLES  in  16  leading samples run with IS_TRAIN=1, sampled at START
TRAIN_EN  in  1  global train enable, sampled at START
POS_INIT  in  1  IS_POS value for sample 0, sampled at START
MEM_EN  out  1  read strobe
MEM_ADDR  out  MEM_AW  byte address
MEM_RDATA  in  8  read data, valid the cycle after MEM_EN
AERIN_ADDR  out  12  event address; pixel p is {2'b00,p[9:0]}
AERIN_REQ  out  1  4-phase request
AERIN_ACK  in  1  4-phase acknowledge
PROCESS_DONE  in  1  core end-of-sample pulse
IS_POS  out  1  positive/negative phase select
IS_TRAIN  out  1  train mode
SAMPLE_IDX  out  16  current sample index
BUSY  out  1  high from accepted START until DONE
DONE  out  1  1-cycle pulse after the last sample completes

Behaviour:
- Reset values: all outputs 0, state IDLE. Async assert drops AERIN_REQ immediately. No event or memory read resumes after reset release until a new START.
- Memory layout: sample s, step t, byte b is at s*(N_PIX*T_STEPS/8) + t*(N_PIX/8) + b. Held as a running byte pointer reset to 0 on START. Bit 7 of a byte is the lowest pixel index.
- States:
  - IDLE: START -> latch config. Set SAMPLE_IDX=0, IS_POS=POS_INIT, IS_TRAIN=TRAIN_EN&(TRAIN_SAMPLES!=0). Go to FETCH. If NUM_SAMPLES==0, go to FIN instead.
  - FETCH: MEM_EN=1 for 1 cycle -> LOAD.
  - LOAD: capture MEM_RDATA into the shift register. If the byte is 0, skip to end-of-byte handling. Otherwise go to SCAN.
  - SCAN: examine 1 bit per cycle. Bit=1 -> SETUP with the pixel address. After bit 0 of the byte: if it was not the last byte of the step, pointer++ and go to FETCH; otherwise set the marker address and go to SETUP.
  - SETUP: AERIN_ADDR driven; REQ stays low for exactly 1 cycle (address setup). Also waits here while AERIN_ACK is still high.
  - REQ_HI: AERIN_REQ=1 until AERIN_ACK=1 is sampled.
  - REQ_LO: AERIN_REQ=0 until AERIN_ACK=0 is sampled. Then:
    - after a pixel event, resume SCAN;
    - after a marker, if t<T_STEPS-1, go to t++ then FETCH;
    - otherwise go to WAIT_DONE.
  - WAIT_DONE: on PROCESS_DONE, toggle IS_POS and increment SAMPLE_IDX. Set IS_TRAIN = TRAIN_EN & (new index < TRAIN_SAMPLES). Go to FETCH, or to FIN if the index reaches NUM_SAMPLES.
  - FIN: DONE=1 for 1 cycle, BUSY=0, go to IDLE. IS_POS, IS_TRAIN and SAMPLE_IDX hold their values.
- AERIN_ADDR stays stable from SETUP through the end of REQ_LO. AERIN_REQ is a registered output.
- PROCESS_DONE outside WAIT_DONE is ignored. A PROCESS_DONE on the same edge that WAIT_DONE is entered is not seen; only pulses arriving while in WAIT_DONE count.
- Event order within a step: ascending pixel index, then exactly one marker. A step with no set bits still emits its marker.
- Per-sample cost without waits: T_STEPS markers plus one event per set bit.
- Timing floor with ACK returning immediately: ≥3 cycles per event, and no back-to-back REQ without REQ low for ≥1 cycle.
- START during BUSY has no effect.

Test Plan:
- 1 sample, all-zero bitmap (784 zero bytes), ACK after 2 cycles -> exactly 8 events, all 0x4FF. DONE pulses once after PROCESS_DONE. SAMPLE_IDX=1.
- 1 sample, bits set for pixel 0 at t=0 and pixel 783 at t=7 only -> event sequence 0x000, 0x4FF ×7, 0x30F, 0x4FF. MEM_ADDR covers 0..783 exactly once.
- ACK delayed 25 cycles high and 25 cycles low -> REQ held high until ACK is seen and AERIN_ADDR is stable throughout. No new REQ before ACK falls.
- 3 samples, POS_INIT=1, TRAIN_EN=1, TRAIN_SAMPLES=2 -> (IS_POS, IS_TRAIN) for samples 0..2 = (1,1), (0,1), (1,0). A spurious PROCESS_DONE during streaming changes nothing.
- RST_N asserted while REQ is high mid-sample -> REQ=0 and BUSY=0 immediately. After release, a new START restarts at MEM_ADDR 0 with SAMPLE_IDX=0.
- NUM_SAMPLES=0 -> no MEM_EN and no REQ; DONE pulses 2 cycles after START.
